// File: rtl/mips_run_ctrl.sv
// Run/halt/step sequencer driving the commit enable of the single-cycle MIPS core.
// Define MIPS_CTRL_BREAKPOINT_EN to enable the optional PC breakpoint.
module mips_run_ctrl #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned MAX_CYCLES = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic             halt_req,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      ula_in,
  input  logic             bp_valid,
  input  logic [31:0]      bp_addr,
  output logic             core_en,
  output logic [1:0]       state,
  output logic [1:0]       halt_reason,
  output logic [CNT_W-1:0] instr_count,
  output logic [31:0]      last_pc,
  output logic [31:0]      last_ula
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  localparam logic [1:0] RSN_CMD   = 2'd0;
  localparam logic [1:0] RSN_BP    = 2'd1;
  localparam logic [1:0] RSN_LOOP  = 2'd2;
  localparam logic [1:0] RSN_LIMIT = 2'd3;

  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(MAX_CYCLES);
  localparam bit               LIMIT_EN = (MAX_CYCLES != 0);

  state_e           state_q, state_d;
  logic [1:0]       reason_q, reason_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_c;
  logic [31:0]      last_pc_q, last_pc_d;
  logic [31:0]      last_ula_q, last_ula_d;
  logic             ppv_q, ppv_d;
  logic             bp_hit_c;
  logic             self_loop_c;
  logic             limit_c;

`ifdef MIPS_CTRL_BREAKPOINT_EN
  logic bp_skip_q, bp_skip_d;

  assign bp_hit_c = (state_q == ST_RUN) && bp_valid && (pc_in == bp_addr) && !bp_skip_q;

  // Skip is armed on resume from HALT so the core can move past the breakpoint PC.
  always_comb begin
    bp_skip_d = bp_skip_q;
    if (core_en) begin
      bp_skip_d = 1'b0;
    end
    if ((state_q == ST_HALT) && !halt_req && (step || start)) begin
      bp_skip_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bp_skip_q <= 1'b0;
    end else begin
      bp_skip_q <= bp_skip_d;
    end
  end
`else
  logic unused_bp_c;
  assign unused_bp_c = ^{bp_valid, bp_addr};
  assign bp_hit_c    = 1'b0;
`endif

  assign cnt_inc_c   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign self_loop_c = ppv_q && (pc_in == last_pc_q);
  assign limit_c     = LIMIT_EN && (cnt_inc_c == LIMIT);

  always_comb begin
    state_d    = state_q;
    reason_d   = reason_q;
    cnt_d      = cnt_q;
    last_pc_d  = last_pc_q;
    last_ula_d = last_ula_q;
    ppv_d      = ppv_q;
    core_en    = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !bp_hit_c;

    if (core_en) begin
      cnt_d      = cnt_inc_c;
      last_pc_d  = pc_in;
      last_ula_d = ula_in;
      ppv_d      = 1'b1;
    end

    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        if (!halt_req) begin
          if (step) begin
            state_d = ST_STEP;
            ppv_d   = 1'b0;
          end else if (start) begin
            state_d = ST_RUN;
            ppv_d   = 1'b0;
          end
        end
      end
      ST_RUN: begin
        // A breakpoint hit suppresses the commit; other exits let it commit.
        if (bp_hit_c) begin
          state_d  = ST_HALT;
          reason_d = RSN_BP;
        end else if (halt_req) begin
          state_d  = ST_HALT;
          reason_d = RSN_CMD;
        end else if (self_loop_c) begin
          state_d  = ST_HALT;
          reason_d = RSN_LOOP;
        end else if (limit_c) begin
          state_d  = ST_HALT;
          reason_d = RSN_LIMIT;
        end
      end
      ST_STEP: begin
        state_d  = ST_HALT;
        reason_d = RSN_CMD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      reason_q   <= RSN_CMD;
      cnt_q      <= '0;
      last_pc_q  <= '0;
      last_ula_q <= '0;
      ppv_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      reason_q   <= reason_d;
      cnt_q      <= cnt_d;
      last_pc_q  <= last_pc_d;
      last_ula_q <= last_ula_d;
      ppv_q      <= ppv_d;
    end
  end

  assign state       = state_q;
  assign halt_reason = reason_q;
  assign instr_count = cnt_q;
  assign last_pc     = last_pc_q;
  assign last_ula    = last_ula_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: directed vector table, hand sequences and a randomized run
// against a rule-level reference model (MIPS_CTRL_BREAKPOINT_EN aware).
module tb_mips_run_ctrl;

  localparam logic [31:0] ULA_X = 32'h5A5A_0000;

  logic        clock    = 1'b1;
  logic        reset    = 1'b1;
  logic        start    = 1'b0;
  logic        step     = 1'b0;
  logic        halt_req = 1'b0;
  logic [31:0] pc_in    = '0;
  logic [31:0] ula_in   = '0;
  logic        bp_valid = 1'b0;
  logic [31:0] bp_addr  = '0;

  logic        core_en, s_core_en;
  logic [1:0]  state, halt_reason, s_state, s_halt_reason;
  logic [31:0] instr_count, last_pc, last_ula, s_last_pc, s_last_ula;
  logic [3:0]  s_instr_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mips_run_ctrl #(.CNT_W(32), .MAX_CYCLES(16)) u_dut (
    .clock(clock), .reset(reset), .start(start), .step(step), .halt_req(halt_req),
    .pc_in(pc_in), .ula_in(ula_in), .bp_valid(bp_valid), .bp_addr(bp_addr),
    .core_en(core_en), .state(state), .halt_reason(halt_reason),
    .instr_count(instr_count), .last_pc(last_pc), .last_ula(last_ula)
  );

  // Narrow counter, no limit: exercises saturation.
  mips_run_ctrl #(.CNT_W(4), .MAX_CYCLES(0)) u_sat (
    .clock(clock), .reset(reset), .start(start), .step(step), .halt_req(halt_req),
    .pc_in(pc_in), .ula_in(ula_in), .bp_valid(bp_valid), .bp_addr(bp_addr),
    .core_en(s_core_en), .state(s_state), .halt_reason(s_halt_reason),
    .instr_count(s_instr_count), .last_pc(s_last_pc), .last_ula(s_last_ula)
  );

  typedef struct {
    bit          st, sp, hr;
    logic [31:0] pc;
    logic [1:0]  e_state;
    bit          e_en;
    logic [1:0]  e_rsn;
    logic [31:0] e_cnt, e_lpc;
  } vec_t;

  typedef struct {
    logic [1:0]      st;
    logic [1:0]      rsn;
    longint unsigned cnt;
    logic [31:0]     lpc, lula;
    bit              ppv, skip;
  } mdl_t;

  function automatic vec_t mk(bit st, bit sp, bit hr, logic [31:0] pc, logic [1:0] es,
                              bit een, logic [1:0] er, logic [31:0] ec, logic [31:0] el);
    vec_t v;
    v.st = st; v.sp = sp; v.hr = hr; v.pc = pc;
    v.e_state = es; v.e_en = een; v.e_rsn = er; v.e_cnt = ec; v.e_lpc = el;
    return v;
  endfunction

  function automatic mdl_t mdl_rst();
    mdl_t m;
    m.st = 0; m.rsn = 0; m.cnt = 0; m.lpc = 0; m.lula = 0; m.ppv = 0; m.skip = 0;
    return m;
  endfunction

  // The core commits while running or stepping, unless sitting on an armed breakpoint.
  function automatic bit mdl_en(mdl_t m, bit bpv, logic [31:0] bpa, logic [31:0] pc);
    bit hit = 1'b0;
`ifdef MIPS_CTRL_BREAKPOINT_EN
    hit = (m.st == 1) && bpv && (pc == bpa) && !m.skip;
`endif
    return ((m.st == 1) || (m.st == 2)) && !hit;
  endfunction

  function automatic mdl_t mdl_next(mdl_t m, bit st, bit sp, bit hr, bit bpv, logic [31:0] bpa,
                                    logic [31:0] pc, logic [31:0] ula,
                                    longint unsigned lim, longint unsigned cmax);
    mdl_t n = m;
    bit en = mdl_en(m, bpv, bpa, pc);
    if (en) begin
      n.cnt  = (m.cnt >= cmax) ? cmax : m.cnt + 1;
      n.lpc  = pc;
      n.lula = ula;
      n.ppv  = 1'b1;
      n.skip = 1'b0;
    end
    if (m.st == 0 || m.st == 3) begin
      if (!hr && (sp || st)) begin
        n.st  = sp ? 2'd2 : 2'd1;
        n.ppv = 1'b0;
        if (m.st == 3) n.skip = 1'b1;
      end
    end else if (m.st == 2) begin
      n.st = 3; n.rsn = 0;
    end else begin
      if (!en)                             begin n.st = 3; n.rsn = 1; end
      else if (hr)                         begin n.st = 3; n.rsn = 0; end
      else if (m.ppv && pc == m.lpc)       begin n.st = 3; n.rsn = 2; end
      else if (lim != 0 && n.cnt == lim)   begin n.st = 3; n.rsn = 3; end
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_main(input string tag, input logic [1:0] es, input bit een,
                          input logic [1:0] er, input logic [31:0] ec, input logic [31:0] el);
    chk({tag, ".state"}, 32'(state), 32'(es));
    chk({tag, ".core_en"}, 32'(core_en), 32'(een));
    chk({tag, ".halt_reason"}, 32'(halt_reason), 32'(er));
    chk({tag, ".instr_count"}, instr_count, ec);
    chk({tag, ".last_pc"}, last_pc, el);
  endtask

  task automatic cyc(input bit st, input bit sp, input bit hr, input logic [31:0] pc);
    @(negedge clock);
    start = st; step = sp; halt_req = hr; pc_in = pc; ula_in = pc ^ ULA_X;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    start = 0; step = 0; halt_req = 0;
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  vec_t tbl[12];
  mdl_t m_main, m_sat;

  initial begin
    // Self-loop program, then a single step from HALT.
    tbl[0]  = mk(1, 0, 0, 32'h00, 0, 0, 0, 0, 32'h00);
    tbl[1]  = mk(0, 0, 0, 32'h00, 1, 1, 0, 0, 32'h00);
    tbl[2]  = mk(0, 0, 0, 32'h04, 1, 1, 0, 1, 32'h00);
    tbl[3]  = mk(0, 0, 0, 32'h08, 1, 1, 0, 2, 32'h04);
    tbl[4]  = mk(0, 0, 0, 32'h0C, 1, 1, 0, 3, 32'h08);
    tbl[5]  = mk(0, 0, 0, 32'h10, 1, 1, 0, 4, 32'h0C);
    tbl[6]  = mk(0, 0, 0, 32'h14, 1, 1, 0, 5, 32'h10);
    tbl[7]  = mk(0, 0, 0, 32'h14, 1, 1, 0, 6, 32'h14);
    tbl[8]  = mk(0, 0, 0, 32'h14, 3, 0, 2, 7, 32'h14);
    tbl[9]  = mk(0, 1, 0, 32'h08, 3, 0, 2, 7, 32'h14);
    tbl[10] = mk(0, 0, 0, 32'h08, 2, 1, 2, 7, 32'h14);
    tbl[11] = mk(0, 0, 0, 32'h08, 3, 0, 0, 8, 32'h08);

    #24;
    chk_main("rst_hold", 0, 0, 0, 0, 0);
    reset = 1'b0;
    #2;
    chk_main("rst_rel", 0, 0, 0, 0, 0);
    chk("rst_rel.last_ula", last_ula, 0);
    chk("rst_rel.sat_cnt", 32'(s_instr_count), 0);

    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].st, tbl[i].sp, tbl[i].hr, tbl[i].pc);
      chk_main($sformatf("vec%0d", i), tbl[i].e_state, tbl[i].e_en, tbl[i].e_rsn,
               tbl[i].e_cnt, tbl[i].e_lpc);
      chk($sformatf("vec%0d.last_ula", i), last_ula,
          (tbl[i].e_cnt == 0) ? 32'h0 : (tbl[i].e_lpc ^ ULA_X));
    end

    // halt_req three cycles into a run; then all three commands together.
    do_reset();
    cyc(1, 0, 0, 32'h00);
    cyc(0, 0, 0, 32'h00);
    cyc(0, 0, 0, 32'h04);
    cyc(0, 0, 0, 32'h08);
    cyc(0, 0, 1, 32'h0C);
    chk("halt.core_en_before", 32'(core_en), 1);
    cyc(0, 0, 0, 32'h10);
    chk_main("halt", 3, 0, 0, 4, 32'h0C);
    cyc(1, 0, 0, 32'h10);
    cyc(0, 0, 0, 32'h10);
    cyc(1, 1, 1, 32'h14);
    cyc(0, 0, 0, 32'h14);
    chk_main("all_cmds", 3, 0, 0, 6, 32'h14);

    // Cycle limit on the main instance, saturation on the narrow one.
    do_reset();
    cyc(1, 0, 0, 32'h00);
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, 32'(i * 4));
    cyc(0, 0, 0, 32'h40);
    chk_main("limit", 3, 0, 3, 16, 32'h3C);
    chk("sat.instr_count", 32'(s_instr_count), 15);
    chk("sat.state", 32'(s_state), 1);

    // Reset mid-run acts without a clock edge.
    do_reset();
    cyc(1, 0, 0, 32'h00);
    cyc(0, 0, 0, 32'h00);
    cyc(0, 0, 0, 32'h04);
    chk("midrst.core_en_before", 32'(core_en), 1);
    reset = 1'b1;
    #1;
    chk("midrst.core_en", 32'(core_en), 0);
    chk("midrst.state", 32'(state), 0);
    chk("midrst.instr_count", instr_count, 0);
    chk("midrst.sat_core_en", 32'(s_core_en), 0);
    reset = 1'b0;

`ifdef MIPS_CTRL_BREAKPOINT_EN
    do_reset();
    bp_valid = 1'b1;
    bp_addr  = 32'h0C;
    cyc(1, 0, 0, 32'h00);
    cyc(0, 0, 0, 32'h00);
    cyc(0, 0, 0, 32'h04);
    cyc(0, 0, 0, 32'h08);
    cyc(0, 0, 1, 32'h0C);
    chk("bp.core_en_at_hit", 32'(core_en), 0);
    cyc(0, 0, 0, 32'h0C);
    chk_main("bp_hit", 3, 0, 1, 3, 32'h08);
    cyc(1, 0, 0, 32'h0C);
    cyc(0, 0, 0, 32'h0C);
    chk("bp.core_en_resume", 32'(core_en), 1);
    cyc(0, 0, 0, 32'h10);
    chk_main("bp_resume", 1, 1, 1, 4, 32'h0C);
    cyc(0, 0, 1, 32'h14);
    cyc(0, 0, 0, 32'h14);
    chk_main("bp_stop", 3, 0, 0, 6, 32'h14);
    bp_valid = 1'b0;
`endif

    // Randomized run against the reference model.
    do_reset();
    m_main = mdl_rst();
    m_sat  = mdl_rst();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      start    = ($urandom_range(0, 9) == 0);
      step     = ($urandom_range(0, 15) == 0);
      halt_req = ($urandom_range(0, 19) == 0);
      pc_in    = ($urandom_range(0, 7) == 0) ? pc_in : ((pc_in + 32'd4) & 32'h3C);
      ula_in   = $urandom;
      bp_valid = ($urandom_range(0, 3) != 0);
      bp_addr  = 32'($urandom_range(0, 15)) << 2;
      if ($urandom_range(0, 249) == 0) begin
        reset = 1'b1;
        #1;
        m_main = mdl_rst();
        m_sat  = mdl_rst();
        reset  = 1'b0;
      end else begin
        #1;
      end
      chk("rnd.state", 32'(state), 32'(m_main.st));
      chk("rnd.core_en", 32'(core_en), 32'(mdl_en(m_main, bp_valid, bp_addr, pc_in)));
      chk("rnd.halt_reason", 32'(halt_reason), 32'(m_main.rsn));
      chk("rnd.instr_count", instr_count, 32'(m_main.cnt));
      chk("rnd.last_pc", last_pc, m_main.lpc);
      chk("rnd.last_ula", last_ula, m_main.lula);
      chk("rnd.sat_state", 32'(s_state), 32'(m_sat.st));
      chk("rnd.sat_core_en", 32'(s_core_en), 32'(mdl_en(m_sat, bp_valid, bp_addr, pc_in)));
      chk("rnd.sat_halt_reason", 32'(s_halt_reason), 32'(m_sat.rsn));
      chk("rnd.sat_instr_count", 32'(s_instr_count), 32'(m_sat.cnt));
      chk("rnd.sat_last_pc", s_last_pc, m_sat.lpc);
      chk("rnd.sat_last_ula", s_last_ula, m_sat.lula);
      m_main = mdl_next(m_main, start, step, halt_req, bp_valid, bp_addr, pc_in, ula_in,
                        16, 64'h0000_0000_FFFF_FFFF);
      m_sat  = mdl_next(m_sat, start, step, halt_req, bp_valid, bp_addr, pc_in, ula_in,
                        0, 15);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
